// File: rtl/key_event_decoder_if.sv
// Key event bundle: debounced key level in, registered event pulses and press counter out.
// The decoder takes the slave side and the consumer takes the master side.
interface key_event_decoder_if;
   logic       keyin;
   logic       held;
   logic       press;
   logic       key_release;
   logic       short_click;
   logic       long_press;
   logic       key_repeat;
   logic [7:0] press_count;

   modport master (
      output keyin,
      input  held,
      input  press,
      input  key_release,
      input  short_click,
      input  long_press,
      input  key_repeat,
      input  press_count
   );

   modport slave (
      input  keyin,
      output held,
      output press,
      output key_release,
      output short_click,
      output long_press,
      output key_repeat,
      output press_count
   );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle press/release/click/long/repeat pulses
// and a wrapping press counter. All outputs are registered.
module key_event_decoder #(
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_CYC   = 50,
   parameter int REPEAT_CYC = 10,
   parameter int CNT_W      = 8
) (
   input logic                clk,
   input logic                rst,
   key_event_decoder_if.slave kev
);

   localparam int           CNT_MAX = (1 << CNT_W) - 1;
   localparam logic         POL     = (ACTIVE_LOW != 0);
   localparam logic [CNT_W:0] LONG_TH = (CNT_W + 1)'(LONG_CYC);
   localparam logic [CNT_W:0] REP_TH  = (CNT_W + 1)'(REPEAT_CYC);

   if (CNT_W < 1 || LONG_CYC < 2 || LONG_CYC > CNT_MAX ||
       REPEAT_CYC < 0 || REPEAT_CYC > CNT_MAX) begin : g_bad_params
      $error("key_event_decoder: illegal LONG_CYC/REPEAT_CYC/CNT_W combination");
   end

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W:0]   cnt_inc;
   logic             act;
   logic             press_nx;
   logic             rel_nx;
   logic             short_nx;
   logic             long_nx;
   logic             rpt_nx;

   assign act     = kev.keyin ^ POL;
   // one bit wider so the threshold compare cannot alias on wrap
   assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      short_nx = 1'b0;
      long_nx  = 1'b0;
      rpt_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (act) begin
               press_nx = 1'b1;
               cnt_nx   = (CNT_W)'(1);
               state_nx = PRESSED;
            end
         end
         PRESSED: begin
            if (!act) begin
               rel_nx   = 1'b1;
               short_nx = 1'b1;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (cnt_inc == LONG_TH) begin
               long_nx  = 1'b1;
               cnt_nx   = '0;
               state_nx = LONG;
            end else begin
               cnt_nx = cnt_inc[CNT_W-1:0];
            end
         end
         LONG: begin
            // release is tested first so a release on the repeat edge suppresses the repeat
            if (!act) begin
               rel_nx   = 1'b1;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (REPEAT_CYC == 0) begin
               cnt_nx = '0;
            end else if (cnt_inc == REP_TH) begin
               rpt_nx = 1'b1;
               cnt_nx = '0;
            end else begin
               cnt_nx = cnt_inc[CNT_W-1:0];
            end
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // registered outputs: held follows the next state so it drops together with release
   always_ff @(posedge clk) begin
      if (rst) begin
         kev.held        <= 1'b0;
         kev.press       <= 1'b0;
         kev.key_release <= 1'b0;
         kev.short_click <= 1'b0;
         kev.long_press  <= 1'b0;
         kev.key_repeat  <= 1'b0;
         kev.press_count <= 8'd0;
      end else begin
         kev.held        <= (state_nx != IDLE);
         kev.press       <= press_nx;
         kev.key_release <= rel_nx;
         kev.short_click <= short_nx;
         kev.long_press  <= long_nx;
         kev.key_repeat  <= rpt_nx;
         if (press_nx) begin
            kev.press_count <= kev.press_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: two instances (active-low with repeat, active-high without repeat)
// checked against a hold-length reference model, a hand-written vector table and pulse tallies.
module tb_key_event_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_event_decoder_if ia ();
   key_event_decoder_if ib ();

   key_event_decoder #(.ACTIVE_LOW(1), .LONG_CYC(5), .REPEAT_CYC(3), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .kev(ia)
   );
   key_event_decoder #(.ACTIVE_LOW(0), .LONG_CYC(5), .REPEAT_CYC(0), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .kev(ib)
   );

   // vector bits: {held, press, release, short_click, long_press, repeat, press_count[7:0]}
   typedef struct {
      logic        r;
      logic        k;
      logic [13:0] e;
   } vec_t;

   vec_t        tab[$];
   int          tests = 0;
   int          fails = 0;
   int          ha = 0, hb = 0, pca = 0, pcb = 0;
   logic [13:0] ea, eb, ga, gb;
   int          tal_a[6];
   int          tal_b[6];

   function automatic logic [13:0] mk(input logic h, input logic p, input logic rl, input logic s,
                                      input logic l, input logic t, input int c);
      return {h, p, rl, s, l, t, 8'(c)};
   endfunction

   // h is the number of consecutive pressed samples since the last press; events follow from h alone
   task automatic ref_step(input logic r, input logic act, input int lc, input int rc,
                           inout int h, inout int pc, output logic [13:0] e);
      e = '0;
      if (r) begin
         h  = 0;
         pc = 0;
      end else if (act) begin
         if (h == 0) begin
            e[12] = 1'b1;
            pc    = (pc + 1) % 256;
            h     = 1;
         end else begin
            h = h + 1;
            if (h == lc) e[9] = 1'b1;
            else if (h > lc && rc != 0 && ((h - lc) % rc) == 0) e[8] = 1'b1;
         end
         e[13] = 1'b1;
      end else begin
         if (h > 0) e[11] = 1'b1;
         if (h > 0 && h < lc) e[10] = 1'b1;
         h = 0;
      end
      e[7:0] = 8'(pc);
   endtask

   task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic clear_tally();
      for (int i = 0; i < 6; i++) begin
         tal_a[i] = 0;
         tal_b[i] = 0;
      end
   endtask

   task automatic step(input logic r, input logic ka, input logic kb, input string tag);
      rst      = r;
      ia.keyin = ka;
      ib.keyin = kb;
      @(posedge clk);
      ref_step(r, ~ka, 5, 3, ha, pca, ea);
      ref_step(r, kb, 5, 0, hb, pcb, eb);
      #1;
      ga = {ia.held, ia.press, ia.key_release, ia.short_click, ia.long_press, ia.key_repeat,
            ia.press_count};
      gb = {ib.held, ib.press, ib.key_release, ib.short_click, ib.long_press, ib.key_repeat,
            ib.press_count};
      for (int i = 0; i < 6; i++) begin
         if (ga[13-i]) tal_a[i]++;
         if (gb[13-i]) tal_b[i]++;
      end
      chk({tag, "_a"}, ga, ea);
      chk({tag, "_b"}, gb, eb);
   endtask

   task automatic add(input logic r, input logic k, input logic [13:0] e);
      vec_t v;
      v.r = r;
      v.k = k;
      v.e = e;
      tab.push_back(v);
   endtask

   initial begin
      int  long_idx;
      logic ka, kb;

      // reset, idle, short click, boundary release at 4 and 5 samples, single-sample press
      add(1, 1, mk(0, 0, 0, 0, 0, 0, 0));
      add(1, 1, mk(0, 0, 0, 0, 0, 0, 0));
      add(0, 1, mk(0, 0, 0, 0, 0, 0, 0));
      add(0, 1, mk(0, 0, 0, 0, 0, 0, 0));
      add(0, 0, mk(1, 1, 0, 0, 0, 0, 1));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 1));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 1));
      add(0, 1, mk(0, 0, 1, 1, 0, 0, 1));
      add(0, 1, mk(0, 0, 0, 0, 0, 0, 1));
      add(0, 0, mk(1, 1, 0, 0, 0, 0, 2));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 2));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 2));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 2));
      add(0, 1, mk(0, 0, 1, 1, 0, 0, 2));
      add(0, 0, mk(1, 1, 0, 0, 0, 0, 3));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 3));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 3));
      add(0, 0, mk(1, 0, 0, 0, 0, 0, 3));
      add(0, 0, mk(1, 0, 0, 0, 1, 0, 3));
      add(0, 1, mk(0, 0, 1, 0, 0, 0, 3));
      add(0, 1, mk(0, 0, 0, 0, 0, 0, 3));
      add(0, 0, mk(1, 1, 0, 0, 0, 0, 4));
      add(0, 1, mk(0, 0, 1, 1, 0, 0, 4));

      clear_tally();
      for (int i = 0; i < tab.size(); i++) begin
         step(tab[i].r, tab[i].k, 1'b0, "tab");
         chk($sformatf("tab_vec%0d", i), ga, tab[i].e);
      end

      // 20 idle cycles: no pulses at all
      clear_tally();
      repeat (20) step(0, 1, 0, "idle");
      chk_int("idle_pulses_a", tal_a[1] + tal_a[2] + tal_a[3] + tal_a[4] + tal_a[5], 0);
      chk_int("idle_pulses_b", tal_b[1] + tal_b[2] + tal_b[3] + tal_b[4] + tal_b[5], 0);

      // long hold of 14 samples with repeat every 3
      clear_tally();
      repeat (14) step(0, 0, 0, "long");
      step(0, 1, 0, "long_rel");
      chk_int("long_repeats", tal_a[5], 3);
      chk_int("long_longs", tal_a[4], 1);
      chk_int("long_release", tal_a[2], 1);
      chk_int("long_short", tal_a[3], 0);
      chk_int("long_held", tal_a[0], 14);

      // reset on the third sample of a hold, key still pressed afterwards
      step(0, 0, 0, "rstmid");
      step(0, 0, 0, "rstmid");
      clear_tally();
      step(1, 0, 0, "rstmid_rst");
      chk_int("rstmid_norel", tal_a[2], 0);
      long_idx = -1;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, "rstmid_hold");
         if (i == 0) begin
            chk_int("rstmid_press", int'(ga[12]), 1);
            chk_int("rstmid_count", int'(ga[7:0]), 1);
         end
         if (ga[9] && long_idx < 0) long_idx = i;
      end
      chk_int("rstmid_long_at", long_idx, 4);
      step(0, 1, 0, "rstmid_rel");

      // active-high instance: 256 single-sample presses wrap the counter
      step(1, 1, 0, "wrap_rst");
      clear_tally();
      for (int i = 0; i < 256; i++) begin
         step(0, 1, 1, "wrap_p");
         step(0, 1, 0, "wrap_r");
      end
      chk_int("wrap_shorts", tal_b[3], 256);
      chk_int("wrap_presses", tal_b[1], 256);
      chk_int("wrap_count", int'(gb[7:0]), 0);

      // repeat disabled: a 20-sample hold gives one long_press only
      clear_tally();
      repeat (20) step(0, 1, 1, "norep");
      step(0, 1, 0, "norep_rel");
      chk_int("norep_longs", tal_b[4], 1);
      chk_int("norep_repeats", tal_b[5], 0);
      chk_int("norep_short", tal_b[3], 0);

      // random hold lengths and occasional resets
      ka = 1'b1;
      kb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) ka = ~ka;
         if ($urandom_range(9) == 0) kb = ~kb;
         step(($urandom_range(149) == 0), ka, kb, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
